vfifo_sc_ctrl: RTL

Single-clock FIFO controller that sequences one vfifo dual-port RAM instance (write port A, registered-address read port B) as a show-ahead FIFO.
- Owns the read/write pointers, fill level, full/empty and almost flags, and sticky error flags.
- Presents valid/ready handshakes on both sides.
- Sits between a producer and a consumer in the same clock domain; the RAM's clk_a and clk_b are both tied to clk.

---
 rtl/vfifo_pkg.sv | 49 ++++
 rtl/vfifo_dual_port_ram_dc_sw.sv | 31 +++
 rtl/vfifo_sc_flags.sv | 67 ++++++
 rtl/vfifo_sc_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/vfifo_pkg.sv
// Shared helpers for the vfifo controller: pointer/depth derivation and fill-level flag decode.
package vfifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fill_flags_t;

    localparam fill_flags_t FLAGS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    // One extra pointer bit distinguishes a full FIFO from an empty one.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic logic level_ge(input int unsigned level, input int unsigned thresh);
        return level >= thresh;
    endfunction

    function automatic logic level_le(input int unsigned level, input int unsigned thresh);
        return level <= thresh;
    endfunction

    function automatic fill_flags_t level_flags(
        input int unsigned level,
        input int unsigned depth,
        input int unsigned afull_thresh,
        input int unsigned aempty_thresh
    );
        fill_flags_t f;
        f.full         = (level == depth);
        f.empty        = (level == 0);
        f.almost_full  = level_ge(level, afull_thresh);
        f.almost_empty = level_le(level, aempty_thresh);
        return f;
    endfunction

endpackage

// File: rtl/vfifo_dual_port_ram_dc_sw.sv
// Dual-port RAM: synchronous write on port A, registered-address read on port B.
module vfifo_dual_port_ram_dc_sw #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk_a,
    input  logic [DATA_WIDTH-1:0] d_a,
    input  logic [ADDR_WIDTH-1:0] adr_a,
    input  logic                  we_a,
    input  logic                  clk_b,
    input  logic [ADDR_WIDTH-1:0] adr_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] adr_b_q;

    always_ff @(posedge clk_a) begin
        if (we_a) begin
            mem[adr_a] <= d_a;
        end
    end

    always_ff @(posedge clk_b) begin
        adr_b_q <= adr_b;
    end

    // Reading through the registered address makes a same-edge write visible immediately.
    assign q_b = mem[adr_b_q];

endmodule

// File: rtl/vfifo_sc_flags.sv
// Registered fill flags derived from the next-cycle level, plus sticky overflow/underflow.
module vfifo_sc_flags
    import vfifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 9,
    parameter int unsigned AFULL_THRESH  = 2 ** ADDR_WIDTH - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_flags,
    input  logic [ADDR_WIDTH:0] level_nxt,
    input  logic                ovf_event,
    input  logic                udf_event,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                overflow,
    output logic                underflow
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    fill_flags_t flags_d, flags_q;
    logic        overflow_d, overflow_q;
    logic        underflow_d, underflow_q;

    always_comb begin
        flags_d = level_flags(32'(level_nxt), DEPTH, AFULL_THRESH, AEMPTY_THRESH);

        // A new error event beats a coincident clear.
        overflow_d = overflow_q;
        if (ovf_event) begin
            overflow_d = 1'b1;
        end else if (clear_flags) begin
            overflow_d = 1'b0;
        end

        underflow_d = underflow_q;
        if (udf_event) begin
            underflow_d = 1'b1;
        end else if (clear_flags) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q     <= FLAGS_RST;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: rtl/vfifo_sc_ctrl.sv
// Single-clock show-ahead FIFO controller driving a vfifo dual-port RAM.
module vfifo_sc_ctrl
    import vfifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 9,
    parameter int unsigned AFULL_THRESH  = 2 ** ADDR_WIDTH - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clear_flags,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DATA_WIDTH-1:0] ram_d,
    output logic [ADDR_WIDTH-1:0] ram_adr_a,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_adr_b,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int unsigned PTR_WIDTH = ptr_width(ADDR_WIDTH);

    logic [PTR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
    logic [PTR_WIDTH-1:0] level_d, level_q;
    logic                 wr_fire, rd_fire;
    logic                 ovf_event, udf_event;

    assign wr_ready = ~full;
    assign rd_valid = ~empty;

    assign wr_fire = wr_valid & wr_ready & ~flush & ~rst;
    assign rd_fire = rd_valid & rd_ready & ~flush & ~rst;

    assign ovf_event = wr_valid & full & ~flush & ~rst;
    assign udf_event = rd_ready & empty & ~flush & ~rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_WIDTH'(wr_fire);
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(rd_fire);
        level_d  = level_q + PTR_WIDTH'(wr_fire) - PTR_WIDTH'(rd_fire);
        if (rst || flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign ram_we    = wr_fire;
    assign ram_adr_a = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_d     = wr_data;

    // The RAM registers this address, so its output tracks the head at rd_ptr after each edge.
    assign ram_adr_b = rd_ptr_d[ADDR_WIDTH-1:0];
    assign rd_data   = ram_q;

    assign level = level_q;

    vfifo_sc_flags #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .AFULL_THRESH  (AFULL_THRESH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) u_flags (
        .clk          (clk),
        .rst          (rst),
        .clear_flags  (clear_flags),
        .level_nxt    (level_d),
        .ovf_event    (ovf_event),
        .udf_event    (udf_event),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

endmodule
